i2s_to_lj_ratio_conv: RTL and testbench

//  Converts a 2-channel I2S or LJ input stream into a left-justified (LJ) stream for the 701 DAC path.
//  The output bit clock is the input BCK divided by DIV; the block keeps the top OUT_WIDTH bits of each word.

---
 rtl/i2s_to_lj_ratio_conv.sv | 121 ++++++++++++
 tb/tb_i2s_to_lj_ratio_conv.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_to_lj_ratio_conv.sv
// I2S/LJ to LJ converter: bck/DIV output clock, top OUT_WIDTH bits,
// one-channel delay through a capture/shift double buffer, muted until framing locks.
module i2s_to_lj_ratio_conv #(
  parameter int IN_BITS_PER_CH = 64,
  parameter int DIV            = 4,
  parameter int OUT_WIDTH      = 16,
  parameter int IN_FMT         = 0,
  parameter int LOCK_CNT       = 2
) (
  input  logic bck,
  input  logic rst_n,
  input  logic lrck,
  input  logic data,
  output logic bck_701,
  output logic lrck_701,
  output logic data_701,
  output logic locked,
  output logic frame_err
);

  localparam int CW = $clog2(IN_BITS_PER_CH + 1);
  localparam int DW = $clog2(DIV);
  localparam int GW = $clog2(LOCK_CNT + 1);

  logic                 lrck_q;
  logic                 la_q, la_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [OUT_WIDTH-1:0] cap_q, cap_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;
  logic [DW-1:0]        div_q, div_d;
  logic                 bck_q, bck_d;
  logic                 lr701_q, lr701_d;
  logic                 lock_q, lock_d;
  logic [GW-1:0]        good_q, good_d;
  logic                 seen_q, seen_d;
  logic                 err_q, err_d;
  logic                 edge_c;

  // I2S data lags lrck by one bck, so delay lrck to line its edge up with the MSB
  assign la_d   = (IN_FMT != 0) ? lrck : lrck_q;
  assign edge_c = la_d ^ la_q;

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    cap_d     = cap_q;
    out_d     = out_q;
    div_d     = div_q;
    lr701_d   = lr701_q;
    lock_d    = lock_q;
    good_d    = good_q;
    seen_d    = seen_q;
    err_d     = 1'b0;
    if (edge_c) begin
      bit_cnt_d = '0;
      cap_d     = {cap_q[OUT_WIDTH-2:0], data};
      seen_d    = 1'b1;
      if (seen_q) begin
        if (bit_cnt_q == CW'(IN_BITS_PER_CH - 1)) begin
          if (good_q != GW'(LOCK_CNT)) good_d = good_q + 1'b1;
          lock_d = (good_d == GW'(LOCK_CNT));
        end else begin
          err_d  = 1'b1;
          good_d = '0;
          lock_d = 1'b0;
        end
      end
      out_d   = lock_d ? cap_q : '0;
      lr701_d = la_q;
      div_d   = '0;
    end else begin
      if (bit_cnt_q != CW'(IN_BITS_PER_CH)) bit_cnt_d = bit_cnt_q + 1'b1;
      if (bit_cnt_q < CW'(OUT_WIDTH - 1)) cap_d = {cap_q[OUT_WIDTH-2:0], data};
      // counter passing the channel length with no edge: lrck stuck or slow
      if (bit_cnt_q == CW'(IN_BITS_PER_CH - 1)) begin
        err_d  = 1'b1;
        good_d = '0;
        lock_d = 1'b0;
      end
      div_d = div_q + 1'b1;
      if (div_q == DW'(DIV - 1)) out_d = {out_q[OUT_WIDTH-2:0], 1'b0};
    end
    bck_d = (div_d >= DW'(DIV / 2));
  end

  always_ff @(posedge bck) begin
    if (!rst_n) begin
      lrck_q    <= 1'b0;
      la_q      <= 1'b0;
      bit_cnt_q <= '0;
      cap_q     <= '0;
      out_q     <= '0;
      div_q     <= '0;
      bck_q     <= 1'b0;
      lr701_q   <= 1'b0;
      lock_q    <= 1'b0;
      good_q    <= '0;
      seen_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      lrck_q    <= lrck;
      la_q      <= la_d;
      bit_cnt_q <= bit_cnt_d;
      cap_q     <= cap_d;
      out_q     <= out_d;
      div_q     <= div_d;
      bck_q     <= bck_d;
      lr701_q   <= lr701_d;
      lock_q    <= lock_d;
      good_q    <= good_d;
      seen_q    <= seen_d;
      err_q     <= err_d;
    end
  end

  assign bck_701   = bck_q;
  assign lrck_701  = lr701_q;
  assign data_701  = out_q[OUT_WIDTH-1];
  assign locked    = lock_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_i2s_to_lj_ratio_conv.sv
// Bench for i2s_to_lj_ratio_conv: I2S and LJ instances on one stream,
// checked against an event-timed reference model plus directed sequences.
module tb_i2s_to_lj_ratio_conv;

  localparam int N   = 64;
  localparam int DIV = 4;
  localparam int OW  = 16;
  localparam int LC  = 2;

  logic bck = 1'b0;
  logic rst_n = 1'b0;
  logic lrck = 1'b0;
  logic lrck_lj = 1'b0;
  logic data = 1'b0;
  logic [1:0] b701, l701, d701, lk, fe;

  i2s_to_lj_ratio_conv #(
    .IN_BITS_PER_CH(N), .DIV(DIV), .OUT_WIDTH(OW), .IN_FMT(0), .LOCK_CNT(LC)
  ) u_i2s (
    .bck(bck), .rst_n(rst_n), .lrck(lrck), .data(data),
    .bck_701(b701[0]), .lrck_701(l701[0]), .data_701(d701[0]),
    .locked(lk[0]), .frame_err(fe[0])
  );

  i2s_to_lj_ratio_conv #(
    .IN_BITS_PER_CH(N), .DIV(DIV), .OUT_WIDTH(OW), .IN_FMT(1), .LOCK_CNT(LC)
  ) u_lj (
    .bck(bck), .rst_n(rst_n), .lrck(lrck_lj), .data(data),
    .bck_701(b701[1]), .lrck_701(l701[1]), .data_701(d701[1]),
    .locked(lk[1]), .frame_err(fe[1])
  );

  always #5 bck = ~bck;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit dh[128];

  int          m_anchor[2];
  bit          m_lrq[2], m_laq[2], m_seen[2], m_lock[2], m_unm[2], m_lr[2], m_err[2];
  int          m_good[2];
  logic [OW-1:0] m_word[2];

  int          errc[2];
  logic [OW-1:0] wsr[2];
  logic [OW:0] wq[2][8];
  int          wn[2];
  bit          pend = 1'b0;

  task automatic model_step(input int k, input bit r, input bit lr);
    bit la;
    m_err[k] = 1'b0;
    if (!r) begin
      m_anchor[k] = cyc; m_lrq[k] = 0; m_laq[k] = 0; m_seen[k] = 0;
      m_lock[k] = 0; m_unm[k] = 0; m_lr[k] = 0; m_good[k] = 0;
      m_word[k] = '0;
      return;
    end
    la = (k == 1) ? lr : m_lrq[k];
    if (la != m_laq[k]) begin
      if (m_seen[k]) begin
        if (cyc - m_anchor[k] == N) begin
          m_good[k] = (m_good[k] < LC) ? m_good[k] + 1 : LC;
          m_lock[k] = (m_good[k] == LC);
        end else begin
          m_err[k] = 1; m_good[k] = 0; m_lock[k] = 0;
        end
      end
      m_seen[k] = 1;
      m_unm[k] = m_lock[k];
      for (int j = 0; j < OW; j++)
        m_word[k][OW-1-j] = dh[(cyc - N + j) & 127];
      m_lr[k] = m_laq[k];
      m_anchor[k] = cyc;
    end else if (cyc - m_anchor[k] == N) begin
      m_err[k] = 1; m_good[k] = 0; m_lock[k] = 0;
    end
    m_lrq[k] = lr;
    m_laq[k] = la;
  endtask

  function automatic logic [4:0] exp_out(input int k);
    int age = cyc - m_anchor[k];
    int j = age / DIV;
    logic dv = 1'b0;
    if (m_unm[k] && j < OW) dv = m_word[k][OW-1-j];
    return {((age % DIV) >= DIV / 2), m_lr[k], dv, m_lock[k], m_err[k]};
  endfunction

  task automatic tick(input bit r, input bit lr, input bit d);
    logic [4:0] got, exp;
    int age;
    @(negedge bck);
    rst_n = r; lrck_lj = lrck; lrck = lr; data = d;
    @(posedge bck);
    cyc++;
    dh[cyc & 127] = d;
    model_step(0, r, lr);
    model_step(1, r, lrck_lj);
    #1;
    for (int k = 0; k < 2; k++) begin
      got = {b701[k], l701[k], d701[k], lk[k], fe[k]};
      exp = exp_out(k);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model k=%0d cyc=%0d got %b exp %b", k, cyc, got, exp);
      end
      if (fe[k]) errc[k]++;
      age = cyc - m_anchor[k];
      if (m_unm[k] && age % DIV == 0 && age / DIV < OW) begin
        wsr[k] = {wsr[k][OW-2:0], d701[k]};
        if (age / DIV == OW - 1 && wn[k] < 8) begin
          wq[k][wn[k]] = {l701[k], wsr[k]};
          wn[k]++;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic half(input bit lr, input logic [63:0] w, input int len,
                      input int rst_at);
    for (int c = 0; c < len; c++) begin
      tick(c != rst_at, lr, pend);
      if (c == rst_at) chk("rst_pulse", {b701, l701, d701, lk, fe}, 0);
      pend = (c < 64) ? w[63-c] : 1'b0;
    end
  endtask

  task automatic chk_lock(input string nm, input int exp);
    chk({nm, "_i2s"}, lk[0], exp);
    chk({nm, "_lj"}, lk[1], exp);
  endtask

  typedef struct packed {
    logic       r;
    logic       lr;
    logic       d;
    logic [4:0] exp;
  } vec_t;

  localparam logic [63:0] WL = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] WR = 64'hABCD_0000_0000_0000;

  initial begin
    vec_t tbl[7];
    int rises, lchg;
    bit pb, pl, lr;
    int len, ra;

    tbl[0] = '{1'b0, 1'b1, 1'b1, 5'b00000};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 5'b00000};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 5'b00000};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 5'b00000};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 5'b10000};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 5'b10000};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 5'b00000};
    for (int i = 0; i < 7; i++) begin
      tick(tbl[i].r, tbl[i].lr, tbl[i].d);
      chk($sformatf("tbl%0d_i2s", i), {b701[0], l701[0], d701[0], lk[0], fe[0]}, tbl[i].exp);
      chk($sformatf("tbl%0d_lj", i), {b701[1], l701[1], d701[1], lk[1], fe[1]}, tbl[i].exp);
    end

    wn[0] = 0; wn[1] = 0;
    half(1, WR, 64, -1); chk_lock("t2_e1", 0);
    half(0, WL, 64, -1); chk_lock("t2_e2", 0);
    half(1, WR, 64, -1); chk_lock("t2_e3", 1);
    half(0, WL, 64, -1);
    half(1, WR, 64, -1);
    half(0, WL, 64, -1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t2_w0_k%0d", k), (wn[k] > 0) ? wq[k][0] : 17'h1FFFF, 17'h01234);
      chk($sformatf("t2_w1_k%0d", k), (wn[k] > 1) ? wq[k][1] : 17'h1FFFF, 17'h1ABCD);
      chk($sformatf("t2_w2_k%0d", k), (wn[k] > 2) ? wq[k][2] : 17'h1FFFF, 17'h01234);
    end

    errc[0] = 0; errc[1] = 0;
    half(1, WR, 63, -1);
    half(0, WL, 64, -1); chk_lock("t4_bad", 0);
    half(1, WR, 64, -1); chk_lock("t4_g1", 0);
    half(0, WL, 64, -1); chk_lock("t4_g2", 1);
    chk("t4_errs_i2s", errc[0], 1);
    chk("t4_errs_lj", errc[1], 1);

    errc[0] = 0; errc[1] = 0;
    rises = 0; lchg = 0; pb = b701[0]; pl = l701[0];
    for (int i = 0; i < 100; i++) begin
      tick(1, 0, 1'($urandom));
      if (b701[0] && !pb) rises++;
      if (l701[0] != pl) lchg++;
      pb = b701[0]; pl = l701[0];
    end
    chk("t5_errs_i2s", errc[0], 1);
    chk("t5_errs_lj", errc[1], 1);
    chk("t5_bck_rises", rises, 25);
    chk("t5_lrck_chg", lchg, 0);

    half(1, WR, 64, -1);
    half(0, WL, 64, -1);
    half(1, WR, 64, -1); chk_lock("t6_pre", 1);
    half(0, WL, 64, 20); chk_lock("t6_rst", 0);
    half(1, WR, 64, -1); chk_lock("t6_e1", 0);
    half(0, WL, 64, -1); chk_lock("t6_e2", 0);
    half(1, WR, 64, -1); chk_lock("t6_e3", 1);

    lr = 1'b1;
    for (int h = 0; h < 40; h++) begin
      lr = ~lr;
      case ($urandom_range(0, 9))
        0: len = 63;
        1: len = 65;
        2: len = 62;
        default: len = 64;
      endcase
      ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      half(lr, {$urandom, $urandom}, len, ra);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
